// File: rtl/temp_threshold_monitor.sv
// Persistence-filtered LT/EQ/GT classifier of temperature samples against a run-time threshold.
// Optional build macro ALARM_LATCH_EN turns alarm into a sticky flag cleared by alarm_clr.
`timescale 1ns/1ps

// state | meaning
// S_LT  | last committed classification: temp below threshold
// S_EQ  | last committed classification: temp equal to threshold
// S_GT  | last committed classification: temp above threshold (held down to thresh-HYST)
module temp_threshold_monitor #(
  parameter int WIDTH   = 4,
  parameter int PERSIST = 3,
  parameter int HYST    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] temp,
  input  logic [WIDTH-1:0] thresh,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             state_chg,
  output logic             alarm,
  input  logic             alarm_clr
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0]  PERSIST_C = CW'(PERSIST);
  localparam logic [CW-1:0]  ONE_C     = CW'(1);
  localparam logic [WIDTH:0] HYST_C    = (WIDTH + 1)'(HYST);

  typedef enum logic [1:0] {
    S_LT = 2'd0,
    S_EQ = 2'd1,
    S_GT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  state_t        pend_cls, pend_nxt;
  state_t        raw_cls;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          chg_nxt;
  logic          state_chg_q;

  logic [WIDTH:0] temp_x, thresh_x, floor_x;

  assign temp_x   = {1'b0, temp};
  assign thresh_x = {1'b0, thresh};

  // Hysteresis floor saturates at zero rather than wrapping.
  always_comb begin
    floor_x = '0;
    if (thresh_x >= HYST_C) begin
      floor_x = thresh_x - HYST_C;
    end
  end

  always_comb begin
    raw_cls = S_LT;
    if (state == S_GT && temp_x >= floor_x) begin
      raw_cls = S_GT;
    end else if (temp_x > thresh_x) begin
      raw_cls = S_GT;
    end else if (temp_x == thresh_x) begin
      raw_cls = S_EQ;
    end else begin
      raw_cls = S_LT;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_cls;
    cnt_nxt   = cnt;
    cnt_inc   = ONE_C;
    chg_nxt   = 1'b0;
    if (sample_valid) begin
      if (raw_cls == state) begin
        cnt_nxt = '0;
      end else begin
        if (raw_cls == pend_cls && cnt != '0) begin
          cnt_inc = cnt + ONE_C;
        end else begin
          pend_nxt = raw_cls;
          cnt_inc  = ONE_C;
        end
        if (cnt_inc == PERSIST_C) begin
          state_nxt = raw_cls;
          cnt_nxt   = '0;
          chg_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LT;
      pend_cls    <= S_LT;
      cnt         <= '0;
      state_chg_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_cls    <= pend_nxt;
      cnt         <= cnt_nxt;
      state_chg_q <= chg_nxt;
    end
  end

  assign lt        = (state == S_LT);
  assign eq        = (state == S_EQ);
  assign gt        = (state == S_GT);
  assign state_chg = state_chg_q;

`ifdef ALARM_LATCH_EN
  logic alarm_q;

  // Entering GT takes precedence over a clear request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else if (state_nxt == S_GT && state != S_GT) begin
      alarm_q <= 1'b1;
    end else if (alarm_clr && state != S_GT) begin
      alarm_q <= 1'b0;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_clr;

  assign unused_alarm_clr = alarm_clr;
  assign alarm            = gt;
`endif

endmodule

// File: tb/tb_temp_threshold_monitor.sv
// Self-checking bench for temp_threshold_monitor: per-cycle compare against an integer model
// plus hand-computed literal checks along a directed sample sequence.
`timescale 1ns/1ps

module tb_temp_threshold_monitor;

  localparam int WIDTH   = 4;
  localparam int PERSIST = 3;
  localparam int HYST    = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] temp = '0;
  logic [WIDTH-1:0] thresh = 4'd12;
  logic             alarm_clr = 1'b0;
  logic             lt, eq, gt, state_chg, alarm;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  temp_threshold_monitor #(.WIDTH(WIDTH), .PERSIST(PERSIST), .HYST(HYST)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .temp(temp), .thresh(thresh),
    .lt(lt), .eq(eq), .gt(gt), .state_chg(state_chg), .alarm(alarm), .alarm_clr(alarm_clr)
  );

  always #5 clk = ~clk;

  // Model: class as integer 0=LT 1=EQ 2=GT, plain integer arithmetic.
  int m_state = 0, m_pend = 0, m_cnt = 0;
  bit m_chg = 1'b0, m_alarm = 1'b0;

  always @(posedge clk) begin
    int t, th, fl, raw, old;
    if (reset) begin
      m_state = 0; m_pend = 0; m_cnt = 0; m_chg = 0; m_alarm = 0;
    end else begin
      old   = m_state;
      m_chg = 0;
      if (sample_valid) begin
        t  = int'(temp);
        th = int'(thresh);
        fl = (th - HYST < 0) ? 0 : th - HYST;
        if (m_state == 2 && t >= fl) raw = 2;
        else if (t > th)             raw = 2;
        else if (t == th)            raw = 1;
        else                         raw = 0;
        if (raw == m_state) m_cnt = 0;
        else begin
          if (raw == m_pend && m_cnt > 0) m_cnt++;
          else begin m_pend = raw; m_cnt = 1; end
          if (m_cnt == PERSIST) begin m_state = raw; m_cnt = 0; m_chg = 1; end
        end
      end
      if (m_state == 2 && old != 2) m_alarm = 1;
      else if (alarm_clr && old != 2) m_alarm = 0;
    end
  end

  function automatic bit exp_alarm(input int st, input bit latched);
`ifdef ALARM_LATCH_EN
    return latched;
`else
    return (st == 2);
`endif
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      checks++;
      if ({lt, eq, gt, state_chg, alarm} !==
          {m_state == 0, m_state == 1, m_state == 2, m_chg, exp_alarm(m_state, m_alarm)}) begin
        failures++;
        $display("FAIL cycle_model t=%0t got lt/eq/gt/chg/alarm=%b%b%b%b%b want %b%b%b%b%b",
                 $time, lt, eq, gt, state_chg, alarm, m_state == 0, m_state == 1,
                 m_state == 2, m_chg, exp_alarm(m_state, m_alarm));
      end
    end
  end

  task automatic smp(input bit v, input int t, input int th);
    sample_valid = v;
    temp   = WIDTH'(t);
    thresh = WIDTH'(th);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic chk(input string name, input bit e_lt, input bit e_eq, input bit e_gt,
                     input bit e_chg);
    checks++;
    if ({lt, eq, gt, state_chg} !== {e_lt, e_eq, e_gt, e_chg}) begin
      failures++;
      $display("FAIL %s got lt/eq/gt/chg=%b%b%b%b want %b%b%b%b", name, lt, eq, gt, state_chg,
               e_lt, e_eq, e_gt, e_chg);
    end
  endtask

  task automatic chk_alarm(input string name, input bit e);
    checks++;
    if (alarm !== e) begin
      failures++;
      $display("FAIL %s got alarm=%b want %b", name, alarm, e);
    end
  endtask

  initial begin
    bit latch_build;
`ifdef ALARM_LATCH_EN
    latch_build = 1'b1;
`else
    latch_build = 1'b0;
`endif
    // 1. reset held two cycles
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", 1, 0, 0, 0);
    chk_alarm("reset_alarm", 0);
    checking = 1'b1;
    reset = 1'b0;

    // 2. enter GT after the third 13
    smp(1, 13, 12); smp(1, 13, 12);
    chk("gt_after2", 1, 0, 0, 0);
    smp(1, 13, 12);
    chk("gt_after3", 0, 0, 1, 1);
    chk_alarm("gt_alarm_set", 1);
    alarm_clr = 1'b1;
    smp(0, 0, 12);
    alarm_clr = 1'b0;
    chk("chg_one_cycle", 0, 0, 1, 0);
    chk_alarm("clr_in_gt_ignored", 1);

    // 3. hysteresis hold, then exit to LT, then EQ
    repeat (3) smp(1, 11, 12);
    chk("hyst_hold", 0, 0, 1, 0);
    repeat (3) smp(1, 10, 12);
    chk("exit_lt", 1, 0, 0, 1);
    chk_alarm("alarm_after_exit", latch_build);
    alarm_clr = 1'b1;
    smp(0, 0, 12);
    alarm_clr = 1'b0;
    chk_alarm("alarm_cleared", 0);
    smp(1, 13, 12); smp(1, 13, 12); smp(1, 5, 12);
    chk("interrupted_lt", 1, 0, 0, 0);
    smp(1, 13, 12);
    chk("restart_count", 1, 0, 0, 0);
    // pending class switch: 13 then 12 x3 -> EQ on third 12
    smp(1, 12, 12); smp(1, 12, 12);
    chk("eq_pending", 1, 0, 0, 0);
    smp(1, 12, 12);
    chk("enter_eq", 0, 1, 0, 1);
    repeat (3) smp(1, 10, 12);
    chk("eq_to_lt", 1, 0, 0, 1);

    // 4. gapped samples
    smp(1, 13, 12); smp(0, 0, 12); smp(0, 0, 12); smp(1, 13, 12); smp(0, 0, 12);
    chk("gap_pending", 1, 0, 0, 0);
    smp(1, 13, 12);
    chk("gap_gt", 0, 0, 1, 1);
    repeat (3) smp(1, 10, 12);
    smp(1, 13, 12); smp(1, 13, 12);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    chk("reset_midcount", 1, 0, 0, 0);
    smp(1, 13, 12);
    chk("reset_discard", 1, 0, 0, 0);
    smp(1, 13, 12);
    chk("fresh_2", 1, 0, 0, 0);
    smp(1, 13, 12);
    chk("fresh_3", 0, 0, 1, 1);

    // 5. saturated floor at thresh=0, then thresh=15 drop
    repeat (5) smp(1, 0, 0);
    chk("sat_floor_hold", 0, 0, 1, 0);
    smp(1, 3, 15); smp(1, 3, 15);
    chk("t15_pending", 0, 0, 1, 0);
    smp(1, 3, 15);
    chk("t15_lt", 1, 0, 0, 1);
    repeat (3) smp(0, 0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
